uart_row_packet_framer: RTL and testbench
=========================================

# uart_row_packet_framer

Byte-level packet framer between `uart_receiver` and the VGA frame buffer in the UART-to-VGA path. It parses row packets (row-index header, fixed-length pixel payload, end word), writes payload bytes to the frame buffer with row/column addresses, and queues answer bytes for `uart_transmiter`. It generalises the fixed 2+240+1 protocol to parametrised header length, payload length and row count. It adds inter-byte timeout, row-range checking and an optional header/end-only acknowledge mode.

## Interface
Parameters:
- `HDR_BYTES`, 2: row-index bytes, 1..4, MSB first.
- `PAYLOAD_BYTES`, 240: data bytes per packet, at least 1.
- `ROWS`, 480: valid row indices are 0..ROWS-1.
- `END_WORD`, 8'hDD: required trailer byte.
- `ACK_EVERY_BYTE`, 1: 1 = answer each payload byte; 0 = answer header and trailer only.
- `TIMEOUT_CYCLES`, 50000: maximum idle clocks between bytes inside a packet.
- `ANS_ROW`, 8'hCC; `ANS_DATA`, 8'hAA; `ANS_OK`, 8'hFF; `ANS_PARTIAL`, 8'h11; `ANS_BAD`, 8'hEE.

Ports:
- `clk`, in, 1: system clock.
- `rst`, in, 1: asynchronous, active-high reset.
- `rx_data`, in, 8: received byte, valid when `rx_done` is high.
- `rx_done`, in, 1: one-cycle byte strobe.
- `tx_busy`, in, 1: transmitter busy.
- `tx_start`, out, 1: one-cycle start pulse to the transmitter.
- `tx_data`, out, 8: answer byte, held stable from `tx_start` until the next `tx_start`.
- `wr_en`, out, 1: frame-buffer write strobe.
- `wr_row`, out, `$clog2(ROWS)`: row address.
- `wr_col`, out, `$clog2(PAYLOAD_BYTES)`: column address.
- `wr_data`, out, 8: pixel byte.
- `pkt_ok`, out, 1: pulse on a good packet.
- `pkt_err`, out, 1: pulse on timeout, bad trailer or bad row.
- `ans_ovf`, out, 1: sticky flag, set when an answer is dropped; cleared only by reset.

## Operation
- States: `HDR`, `PAY`, `TRL`, `DROP`. The reset state is `HDR` with the byte counter at 0.
- `HDR`:
  - Each byte shifts into the row register: `row = {row, rx_data}`.
  - On byte `HDR_BYTES`, if `row < ROWS`: enqueue `ANS_ROW`, go to `PAY`, column = 0.
  - Otherwise: enqueue `ANS_BAD`, pulse `pkt_err`, go to `DROP`.
- `PAY`:
  - Each byte drives `wr_en` for one cycle with `wr_row` = row, `wr_col` = column and `wr_data` = byte. Column then increments.
  - If `ACK_EVERY_BYTE`, enqueue `ANS_DATA`.
  - After byte `PAYLOAD_BYTES`, go to `TRL`. Column never wraps.
- `TRL`:
  - If the byte equals `END_WORD`: enqueue `ANS_OK`, pulse `pkt_ok`.
  - Otherwise: enqueue `ANS_BAD`, pulse `pkt_err`.
  - Go to `HDR` in both cases.
- `DROP`: bytes are ignored, with no writes or answers. `END_WORD` or a timeout returns the block to `HDR` silently.
- Timeout:
  - The idle counter is cleared on every `rx_done` and counts only while in `PAY`, in `TRL`, or in `HDR` with the counter above 0.
  - On reaching `TIMEOUT_CYCLES`: enqueue `ANS_PARTIAL`, then one count byte, then pulse `pkt_err` and go to `HDR`.
  - The count byte is the number of payload bytes received, saturating at 255. It is 0 if the timeout occurs in `HDR`.
  - Timeout in `DROP` produces no answer.
- Answer queue:
  - 4-entry FIFO.
  - An enqueue into a full FIFO is discarded and sets `ans_ovf`. Byte processing and writes continue regardless.
  - A two-byte partial answer needs 2 free entries; if it does not fit, only the bytes that fit are queued.
- Transmit:
  - When the FIFO is non-empty, `tx_busy` = 0 and the holdoff is 0: pop the FIFO, drive `tx_data`, pulse `tx_start`, and load a 2-cycle holdoff. The holdoff covers the `busy` rise latency.
- Reset: all outputs go to 0, the FIFO is emptied, `ans_ovf` = 0, and the state returns to `HDR`. Reset is legal mid-packet; that partial packet is abandoned with no answer.

## Timing
- `rx_done` at cycle N gives:
  - `wr_en`, `pkt_ok` and `pkt_err` at N+1, registered.
  - The FIFO entry visible at N+1.
  - The earliest `tx_start` at N+2.
- Timeout fires on the clock where the idle count reaches `TIMEOUT_CYCLES`. `pkt_err` is asserted on the following cycle.
- A simultaneous `rx_done` and timeout terminal count: the byte wins, the counter clears, and no timeout occurs.
- A simultaneous enqueue and pop on the FIFO is legal, and the occupancy is unchanged.
- The FIFO performs at most one enqueue per cycle. The second partial-answer byte is enqueued on the cycle after the first.

## Test plan
- Defaults, bytes `01 22`, 240 random bytes, `DD`:
  - Answers `CC`, then 240×`AA`, then `FF`.
  - 240 writes at row 0x122, columns 0..239 in order.
  - One `pkt_ok` pulse.
- Same packet with the trailer `5A` instead of `DD`: last answer `EE`, `pkt_err` pulses once, and the next valid packet succeeds.
- Header `01 E0` (row 480): answer `EE`. The following 240 bytes and `DD` produce no writes and no answers, and the next packet is accepted.
- Stop after 100 payload bytes and wait `TIMEOUT_CYCLES`+10: answers `11`, then `64`, then `pkt_err`. The state returns to `HDR`.
- `ACK_EVERY_BYTE`=0 with a full packet: only `CC` and `FF` are sent, and all 240 writes still occur.
- Hold `tx_busy`=1 for the whole packet: at most 4 answers are retained and `ans_ovf`=1. Assert `rst` mid-payload: all outputs return to 0 and `ans_ovf` clears.

Source files
------------

// File: rtl/uart_row_packet_framer.sv
// Row-packet framer between the UART receiver and the VGA frame buffer:
// parses header/payload/trailer, writes pixels and queues answer bytes for the UART transmitter.
module uart_row_packet_framer #(
    parameter int         HDR_BYTES      = 2,
    parameter int         PAYLOAD_BYTES  = 240,
    parameter int         ROWS           = 480,
    parameter logic [7:0] END_WORD       = 8'hDD,
    parameter bit         ACK_EVERY_BYTE = 1'b1,
    parameter int         TIMEOUT_CYCLES = 50000,
    parameter logic [7:0] ANS_ROW        = 8'hCC,
    parameter logic [7:0] ANS_DATA       = 8'hAA,
    parameter logic [7:0] ANS_OK         = 8'hFF,
    parameter logic [7:0] ANS_PARTIAL    = 8'h11,
    parameter logic [7:0] ANS_BAD        = 8'hEE,
    localparam int        ROW_W          = (ROWS > 1) ? $clog2(ROWS) : 1,
    localparam int        COL_W          = (PAYLOAD_BYTES > 1) ? $clog2(PAYLOAD_BYTES) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [7:0]       rx_data,
    input  logic             rx_done,
    input  logic             tx_busy,
    output logic             tx_start,
    output logic [7:0]       tx_data,
    output logic             wr_en,
    output logic [ROW_W-1:0] wr_row,
    output logic [COL_W-1:0] wr_col,
    output logic [7:0]       wr_data,
    output logic             pkt_ok,
    output logic             pkt_err,
    output logic             ans_ovf
);

    localparam int HW = 8 * HDR_BYTES;
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [1:0] {HDR, PAY, TRL, DROP} state_t;

    state_t           state;
    logic [HW-1:0]    row;
    logic [2:0]       hdr_cnt;
    logic [COL_W-1:0] col;
    logic [TW-1:0]    idle;
    logic             part_pend;
    logic [7:0]       part_byte;

    logic [7:0]       fifo_mem [4];
    logic [1:0]       rd_ptr;
    logic [1:0]       wr_ptr;
    logic [2:0]       count;
    logic [1:0]       holdoff;

    logic [HW+7:0]    row_cat;
    logic [HW-1:0]    row_next;
    logic             row_ok;
    logic             hdr_last;
    logic             col_last;
    logic             active;
    logic             timeout;
    logic [31:0]      col_ext;
    logic [7:0]       pay_cnt;
    logic             enq;
    logic [7:0]       enq_data;
    logic             lost;
    logic             pop;
    logic             enq_ok;

    // Byte decode, timeout detection and answer-queue arbitration
    always_comb begin
        row_cat  = {row, rx_data};
        row_next = row_cat[HW-1:0];
        row_ok   = (64'(row_next) < 64'(ROWS));
        hdr_last = (hdr_cnt == 3'(HDR_BYTES - 1));
        col_last = (col == COL_W'(PAYLOAD_BYTES - 1));
        active   = (state != HDR) || (hdr_cnt != 3'd0);
        timeout  = active && !rx_done && (idle == TW'(TIMEOUT_CYCLES - 1));
        col_ext  = 32'(col);
        // Count byte of a partial answer: payload bytes seen so far, saturated
        if (state == PAY) begin
            pay_cnt = (col_ext > 32'd255) ? 8'hFF : col_ext[7:0];
        end else if (state == TRL) begin
            pay_cnt = (PAYLOAD_BYTES > 255) ? 8'hFF : 8'(PAYLOAD_BYTES);
        end else begin
            pay_cnt = 8'h00;
        end
        enq      = 1'b0;
        enq_data = 8'h00;
        if (part_pend) begin
            enq      = 1'b1;
            enq_data = part_byte;
        end else if (timeout && (state != DROP)) begin
            enq      = 1'b1;
            enq_data = ANS_PARTIAL;
        end else if (rx_done) begin
            case (state)
                HDR: begin
                    if (hdr_last) begin
                        enq      = 1'b1;
                        enq_data = row_ok ? ANS_ROW : ANS_BAD;
                    end else begin
                        enq = 1'b0;
                    end
                end
                PAY: begin
                    enq      = ACK_EVERY_BYTE;
                    enq_data = ANS_DATA;
                end
                TRL: begin
                    enq      = 1'b1;
                    enq_data = (rx_data == END_WORD) ? ANS_OK : ANS_BAD;
                end
                default: enq = 1'b0;
            endcase
        end else begin
            enq = 1'b0;
        end
        // A header answer colliding with the pending count byte cannot be queued
        lost   = part_pend && rx_done && (state == HDR) && hdr_last;
        pop    = (count != 3'd0) && !tx_busy && (holdoff == 2'd0);
        enq_ok = enq && ((count != 3'd4) || pop);
    end

    // Packet FSM with registered write and status outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= HDR;
            row       <= '0;
            hdr_cnt   <= 3'd0;
            col       <= '0;
            idle      <= '0;
            part_pend <= 1'b0;
            part_byte <= 8'h00;
            wr_en     <= 1'b0;
            wr_row    <= '0;
            wr_col    <= '0;
            wr_data   <= 8'h00;
            pkt_ok    <= 1'b0;
            pkt_err   <= 1'b0;
        end else begin
            wr_en     <= 1'b0;
            pkt_ok    <= 1'b0;
            pkt_err   <= 1'b0;
            part_pend <= 1'b0;
            if (rx_done || !active || timeout) begin
                idle <= '0;
            end else begin
                idle <= idle + TW'(1);
            end
            if (timeout) begin
                state   <= HDR;
                hdr_cnt <= 3'd0;
                if (state != DROP) begin
                    part_pend <= 1'b1;
                    part_byte <= pay_cnt;
                    pkt_err   <= 1'b1;
                end
            end else if (rx_done) begin
                case (state)
                    HDR: begin
                        row <= row_next;
                        if (hdr_last) begin
                            hdr_cnt <= 3'd0;
                            col     <= '0;
                            if (row_ok) begin
                                state <= PAY;
                            end else begin
                                state   <= DROP;
                                pkt_err <= 1'b1;
                            end
                        end else begin
                            hdr_cnt <= hdr_cnt + 3'd1;
                        end
                    end
                    PAY: begin
                        wr_en   <= 1'b1;
                        wr_row  <= ROW_W'(row);
                        wr_col  <= col;
                        wr_data <= rx_data;
                        if (col_last) begin
                            state <= TRL;
                        end else begin
                            col <= col + COL_W'(1);
                        end
                    end
                    TRL: begin
                        state <= HDR;
                        if (rx_data == END_WORD) begin
                            pkt_ok <= 1'b1;
                        end else begin
                            pkt_err <= 1'b1;
                        end
                    end
                    DROP: begin
                        if (rx_data == END_WORD) begin
                            state <= HDR;
                        end
                    end
                    default: state <= HDR;
                endcase
            end
        end
    end

    // Answer FIFO and transmit launcher; holdoff masks the busy rise latency
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 4; i++) begin
                fifo_mem[i] <= 8'h00;
            end
            rd_ptr   <= 2'd0;
            wr_ptr   <= 2'd0;
            count    <= 3'd0;
            holdoff  <= 2'd0;
            tx_start <= 1'b0;
            tx_data  <= 8'h00;
            ans_ovf  <= 1'b0;
        end else begin
            if (enq_ok) begin
                fifo_mem[wr_ptr] <= enq_data;
                wr_ptr           <= wr_ptr + 2'd1;
            end
            if (pop) begin
                rd_ptr   <= rd_ptr + 2'd1;
                tx_data  <= fifo_mem[rd_ptr];
                tx_start <= 1'b1;
                holdoff  <= 2'd2;
            end else begin
                tx_start <= 1'b0;
                if (holdoff != 2'd0) begin
                    holdoff <= holdoff - 2'd1;
                end
            end
            case ({enq_ok, pop})
                2'b10:   count <= count + 3'd1;
                2'b01:   count <= count - 3'd1;
                default: count <= count;
            endcase
            if ((enq && !enq_ok) || lost) begin
                ans_ovf <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_uart_row_packet_framer.sv
// Directed self-checking bench for uart_row_packet_framer (default instance plus a
// header/trailer-only acknowledge instance sharing the same byte stream).
module tb_uart_row_packet_framer;

    localparam int TMO = 1000;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] rx_data;
    logic       rx_done;
    logic       tx_busy;

    logic       tx_start, wr_en, pkt_ok, pkt_err, ans_ovf;
    logic [7:0] tx_data, wr_data;
    logic [8:0] wr_row;
    logic [7:0] wr_col;

    logic       tx_start0, wr_en0, pkt_ok0, pkt_err0, ans_ovf0;
    logic [7:0] tx_data0, wr_data0;
    logic [8:0] wr_row0;
    logic [7:0] wr_col0;

    int checks = 0;
    int errors = 0;

    logic [7:0] txq [$];
    logic [7:0] txq0 [$];
    logic [8:0] wrow [$];
    logic [7:0] wcol [$];
    logic [7:0] wdat [$];
    int         wr0_cnt;
    int         ok_cnt;
    int         err_cnt;
    logic [7:0] pay [240];

    always #5 clk = ~clk;

    uart_row_packet_framer #(.TIMEOUT_CYCLES(TMO)) dut (
        .clk(clk), .rst(rst), .rx_data(rx_data), .rx_done(rx_done), .tx_busy(tx_busy),
        .tx_start(tx_start), .tx_data(tx_data), .wr_en(wr_en), .wr_row(wr_row),
        .wr_col(wr_col), .wr_data(wr_data), .pkt_ok(pkt_ok), .pkt_err(pkt_err),
        .ans_ovf(ans_ovf)
    );

    uart_row_packet_framer #(.TIMEOUT_CYCLES(TMO), .ACK_EVERY_BYTE(1'b0)) dut0 (
        .clk(clk), .rst(rst), .rx_data(rx_data), .rx_done(rx_done), .tx_busy(tx_busy),
        .tx_start(tx_start0), .tx_data(tx_data0), .wr_en(wr_en0), .wr_row(wr_row0),
        .wr_col(wr_col0), .wr_data(wr_data0), .pkt_ok(pkt_ok0), .pkt_err(pkt_err0),
        .ans_ovf(ans_ovf0)
    );

    // Output recorder, sampled on the falling edge
    always @(negedge clk) begin
        if (tx_start) txq.push_back(tx_data);
        if (tx_start0) txq0.push_back(tx_data0);
        if (wr_en) begin
            wrow.push_back(wr_row);
            wcol.push_back(wr_col);
            wdat.push_back(wr_data);
        end
        if (wr_en0) wr0_cnt++;
        if (pkt_ok) ok_cnt++;
        if (pkt_err) err_cnt++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        rx_data = b;
        rx_done = 1'b1;
        @(posedge clk);
        #1;
        rx_done = 1'b0;
        wait_cyc(3);
    endtask

    task automatic send_pkt(input logic [7:0] h0, input logic [7:0] h1, input int n,
                            input logic send_trl, input logic [7:0] trl);
        send_byte(h0);
        send_byte(h1);
        for (int i = 0; i < n; i++) begin
            pay[i] = 8'($urandom_range(0, 200));
            send_byte(pay[i]);
        end
        if (send_trl) send_byte(trl);
    endtask

    task automatic clear_log();
        txq.delete();
        txq0.delete();
        wrow.delete();
        wcol.delete();
        wdat.delete();
        wr0_cnt = 0;
        ok_cnt  = 0;
        err_cnt = 0;
    endtask

    // Answers CC, n x AA, then the given tail bytes
    task automatic chk_answers(input string tag, input int n, input logic [7:0] t0,
                               input logic [7:0] t1, input int ntail);
        int aa;
        aa = 0;
        for (int i = 1; i <= n && i < txq.size(); i++) if (txq[i] === 8'hAA) aa++;
        chk({tag, "_ans_len"}, 32'(txq.size()), 32'(n + 1 + ntail));
        chk({tag, "_ans_first"}, 32'(txq[0]), 32'hCC);
        chk({tag, "_ans_data"}, 32'(aa), 32'(n));
        chk({tag, "_ans_tail0"}, 32'(txq[n + 1]), 32'(t0));
        if (ntail == 2) chk({tag, "_ans_tail1"}, 32'(txq[n + 2]), 32'(t1));
    endtask

    task automatic chk_writes(input string tag, input logic [8:0] r, input int n);
        int bad;
        bad = 0;
        for (int i = 0; i < n && i < wrow.size(); i++) begin
            if (wrow[i] !== r || wcol[i] !== 8'(i) || wdat[i] !== pay[i]) bad++;
        end
        chk({tag, "_wr_cnt"}, 32'(wrow.size()), 32'(n));
        chk({tag, "_wr_seq"}, 32'(bad), 32'd0);
    endtask

    initial begin
        rst     = 1'b1;
        rx_data = 8'h00;
        rx_done = 1'b0;
        tx_busy = 1'b0;
        wait_cyc(3);
        chk("rst_outputs", {20'd0, tx_start, wr_en, pkt_ok, pkt_err, ans_ovf, tx_data[0],
                            wr_data[0], wr_row[0], wr_col[0], 3'd0},
            32'd0);
        chk("rst_tx_data", 32'(tx_data), 32'd0);
        rst = 1'b0;
        wait_cyc(2);

        // Good packet at row 0x122
        clear_log();
        send_pkt(8'h01, 8'h22, 240, 1'b1, 8'hDD);
        wait_cyc(20);
        chk_answers("good", 240, 8'hFF, 8'h00, 1);
        chk_writes("good", 9'h122, 240);
        chk("good_ok", 32'(ok_cnt), 32'd1);
        chk("good_err", 32'(err_cnt), 32'd0);
        chk("ack0_len", 32'(txq0.size()), 32'd2);
        chk("ack0_first", 32'(txq0[0]), 32'hCC);
        chk("ack0_last", 32'(txq0[1]), 32'hFF);
        chk("ack0_writes", 32'(wr0_cnt), 32'd240);

        // Bad trailer, then a good packet
        clear_log();
        send_pkt(8'h01, 8'h22, 240, 1'b1, 8'h5A);
        wait_cyc(20);
        chk_answers("badtrl", 240, 8'hEE, 8'h00, 1);
        chk("badtrl_err", 32'(err_cnt), 32'd1);
        chk("badtrl_ok", 32'(ok_cnt), 32'd0);
        clear_log();
        send_pkt(8'h00, 8'h05, 240, 1'b1, 8'hDD);
        wait_cyc(20);
        chk("after_badtrl_ok", 32'(ok_cnt), 32'd1);
        chk_writes("after_badtrl", 9'h005, 240);

        // Row 480 is out of range: dropped packet, then the last valid row
        clear_log();
        send_pkt(8'h01, 8'hE0, 240, 1'b1, 8'hDD);
        wait_cyc(20);
        chk("badrow_len", 32'(txq.size()), 32'd1);
        chk("badrow_ans", 32'(txq[0]), 32'hEE);
        chk("badrow_writes", 32'(wrow.size()), 32'd0);
        chk("badrow_err", 32'(err_cnt), 32'd1);
        clear_log();
        send_pkt(8'h01, 8'hDF, 240, 1'b1, 8'hDD);
        wait_cyc(20);
        chk("row479_ok", 32'(ok_cnt), 32'd1);
        chk_writes("row479", 9'h1DF, 240);

        // Timeout after 100 payload bytes
        clear_log();
        send_pkt(8'h01, 8'h22, 100, 1'b0, 8'h00);
        wait_cyc(TMO + 10);
        chk_answers("tmo", 100, 8'h11, 8'h64, 2);
        chk("tmo_err", 32'(err_cnt), 32'd1);
        chk_writes("tmo", 9'h122, 100);
        clear_log();
        send_pkt(8'h00, 8'h07, 240, 1'b1, 8'hDD);
        wait_cyc(20);
        chk("after_tmo_ok", 32'(ok_cnt), 32'd1);
        chk_answers("after_tmo", 240, 8'hFF, 8'h00, 1);
        chk("no_ovf_yet", 32'(ans_ovf), 32'd0);

        // Transmitter held busy: FIFO keeps 4 answers and flags the overflow
        clear_log();
        tx_busy = 1'b1;
        send_pkt(8'h01, 8'h22, 50, 1'b0, 8'h00);
        chk("busy_none_sent", 32'(txq.size()), 32'd0);
        chk("busy_ovf", 32'(ans_ovf), 32'd1);
        tx_busy = 1'b0;
        wait_cyc(20);
        chk("busy_kept", 32'(txq.size()), 32'd4);
        chk("busy_kept_first", 32'(txq[0]), 32'hCC);
        chk("busy_kept_last", 32'(txq[3]), 32'hAA);
        chk("busy_writes", 32'(wrow.size()), 32'd50);

        // Reset mid-payload with answers queued
        clear_log();
        tx_busy = 1'b1;
        send_byte(8'h11);
        send_byte(8'h22);
        send_byte(8'h33);
        rst = 1'b1;
        #1;
        chk("midrst_ovf", 32'(ans_ovf), 32'd0);
        chk("midrst_outs", {27'd0, tx_start, wr_en, pkt_ok, pkt_err, ans_ovf}, 32'd0);
        chk("midrst_bus", {8'd0, tx_data, wr_data, wr_col}, 32'd0);
        chk("midrst_row", 32'(wr_row), 32'd0);
        wait_cyc(2);
        rst     = 1'b0;
        tx_busy = 1'b0;
        wait_cyc(20);
        chk("midrst_fifo_empty", 32'(txq.size()), 32'd0);
        clear_log();
        send_pkt(8'h00, 8'h09, 240, 1'b1, 8'hDD);
        wait_cyc(20);
        chk_answers("post_rst", 240, 8'hFF, 8'h00, 1);
        chk("post_rst_ok", 32'(ok_cnt), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
